car_traffic_controller: RTL and testbench

- Produces the four car positions that the frog/car collision checker consumes, and consumes that checker's collision flag.
- Cars 1 and 3 travel right; cars 2 and 4 travel left. Each car sits in a fixed lane and wraps around the screen edge.
- Motion is paced by the per-frame tick, with a per-car divider and a level-dependent step size.
- On a collision, traffic freezes for a fixed number of frames, then returns to its start positions.

---
 rtl/car_traffic_controller.sv | 131 +++++++++++++
 tb/tb_car_traffic_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/car_traffic_controller.sv
// Frogger traffic: four cars in fixed lanes, divider-paced wrap-around motion,
// with a timed freeze after a collision that ends by restoring start positions.
module car_traffic_controller #(
  parameter int TILE_SIZE     = 32,
  parameter int SCREEN_W      = 640,
  parameter int CAR1_Y        = 64,
  parameter int CAR2_Y        = 128,
  parameter int CAR3_Y        = 192,
  parameter int CAR4_Y        = 256,
  parameter int CAR1_X0       = 0,
  parameter int CAR2_X0       = 160,
  parameter int CAR3_X0       = 320,
  parameter int CAR4_X0       = 480,
  parameter int CAR1_DIV      = 4,
  parameter int CAR2_DIV      = 3,
  parameter int CAR3_DIV      = 2,
  parameter int CAR4_DIV      = 1,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Run,
  input  logic [1:0] i_Level,
  input  logic       i_Has_Collided,
  output logic [9:0] o_Car1_X,
  output logic [9:0] o_Car2_X,
  output logic [9:0] o_Car3_X,
  output logic [9:0] o_Car4_X,
  output logic [9:0] o_Car1_Y,
  output logic [9:0] o_Car2_Y,
  output logic [9:0] o_Car3_Y,
  output logic [9:0] o_Car4_Y,
  output logic       o_Step,
  output logic       o_Frozen
);

  localparam int FW = $clog2(FREEZE_FRAMES) + 1;

  // Index 0 is car 1; even indices travel right, odd indices travel left.
  localparam logic [3:0][2:0] DIV = {3'(CAR4_DIV), 3'(CAR3_DIV), 3'(CAR2_DIV), 3'(CAR1_DIV)};
  localparam logic [3:0][9:0] X0  = {10'(CAR4_X0), 10'(CAR3_X0), 10'(CAR2_X0), 10'(CAR1_X0)};
  localparam logic [10:0]     SW  = 11'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t          state;
  logic [3:0][9:0] car_x;
  logic [3:0][2:0] div_cnt;
  logic [3:0]      hit;
  logic [FW-1:0]   frz_cnt;

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic right,
                                        input logic [1:0] lvl);
    logic [10:0] s, n;
    s = {9'd0, lvl} + 11'd1;
    if (right) begin
      n = {1'b0, x} + s;
      if (n >= SW) n = n - SW;
    end else if ({1'b0, x} < s) begin
      n = {1'b0, x} + SW - s;
    end else begin
      n = {1'b0, x} - s;
    end
    return n[9:0];
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) hit[i] = (div_cnt[i] == DIV[i] - 3'd1);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= IDLE;
      car_x    <= X0;
      div_cnt  <= '0;
      frz_cnt  <= '0;
      o_Step   <= 1'b0;
      o_Frozen <= 1'b0;
      o_Car1_Y <= 10'(CAR1_Y);
      o_Car2_Y <= 10'(CAR2_Y);
      o_Car3_Y <= 10'(CAR3_Y);
      o_Car4_Y <= 10'(CAR4_Y);
    end else begin
      o_Step <= 1'b0;
      case (state)
        IDLE: if (i_Run) state <= RUN;
        RUN: begin
          if (i_Has_Collided) begin
            state    <= FROZEN;
            frz_cnt  <= '0;
            o_Frozen <= 1'b1;
          end else if (!i_Run) begin
            state <= IDLE;
          end else if (i_Frame_Tick) begin
            for (int i = 0; i < 4; i++) begin
              if (hit[i]) begin
                div_cnt[i] <= '0;
                car_x[i]   <= step_x(car_x[i], ~i[0], i_Level);
              end else begin
                div_cnt[i] <= div_cnt[i] + 3'd1;
              end
            end
            o_Step <= |hit;
          end
        end
        FROZEN: begin
          if (i_Frame_Tick) begin
            if (frz_cnt == FW'(FREEZE_FRAMES - 1)) begin
              state    <= IDLE;
              car_x    <= X0;
              div_cnt  <= '0;
              frz_cnt  <= '0;
              o_Frozen <= 1'b0;
            end else begin
              frz_cnt <= frz_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Car1_X = car_x[0];
  assign o_Car2_X = car_x[1];
  assign o_Car3_X = car_x[2];
  assign o_Car4_X = car_x[3];

endmodule

// File: tb/tb_car_traffic_controller.sv
// Directed bench: a per-cycle vector table for reset/motion/pause/collision,
// plus hand-written freeze, reset-in-freeze and wrap-around sequences.
module tb_car_traffic_controller;

  logic       clk = 1'b0;
  logic       rst, run, tick, coll;
  logic [1:0] lvl;
  logic [9:0] x1, x2, x3, x4, y1, y2, y3, y4;
  logic       step, frz;

  logic       w_rst, w_run, w_tick, w_coll;
  logic [1:0] w_lvl;
  logic [9:0] wx1, wx2, wx3, wx4, wy1, wy2, wy3, wy4;
  logic       w_step, w_frz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_traffic_controller dut (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Tick(tick), .i_Run(run), .i_Level(lvl),
    .i_Has_Collided(coll),
    .o_Car1_X(x1), .o_Car2_X(x2), .o_Car3_X(x3), .o_Car4_X(x4),
    .o_Car1_Y(y1), .o_Car2_Y(y2), .o_Car3_Y(y3), .o_Car4_Y(y4),
    .o_Step(step), .o_Frozen(frz)
  );

  car_traffic_controller #(.CAR1_X0(638), .CAR4_X0(0), .CAR1_DIV(1)) u_wrap (
    .i_Clk(clk), .i_Reset(w_rst), .i_Frame_Tick(w_tick), .i_Run(w_run), .i_Level(w_lvl),
    .i_Has_Collided(w_coll),
    .o_Car1_X(wx1), .o_Car2_X(wx2), .o_Car3_X(wx3), .o_Car4_X(wx4),
    .o_Car1_Y(wy1), .o_Car2_Y(wy2), .o_Car3_Y(wy3), .o_Car4_Y(wy4),
    .o_Step(w_step), .o_Frozen(w_frz)
  );

  typedef struct {
    logic       rst, run, tick, coll;
    logic [1:0] lvl;
    logic [9:0] x1, x2, x3, x4;
    logic       step, frz;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [81:0] act,
                       input logic [9:0] e1, e2, e3, e4, input logic es, ef);
    logic [81:0] exp;
    exp = {e1, e2, e3, e4, 10'd64, 10'd128, 10'd192, 10'd256, es, ef};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d/%0d/%0d/%0d y=%0d/%0d/%0d/%0d step=%0b frozen=%0b, want x=%0d/%0d/%0d/%0d y=64/128/192/256 step=%0b frozen=%0b",
               name, act[81:72], act[71:62], act[61:52], act[51:42], act[41:32],
               act[31:22], act[21:12], act[11:2], act[1], act[0], e1, e2, e3, e4, es, ef);
    end
  endtask

  task automatic cyc(input logic r, ru, t, c, input logic [1:0] l);
    rst = r; run = ru; tick = t; coll = c; lvl = l;
    @(posedge clk); #1;
  endtask

  task automatic wcyc(input logic r, ru, t, input logic [1:0] l);
    w_rst = r; w_run = ru; w_tick = t; w_coll = 1'b0; w_lvl = l;
    @(posedge clk); #1;
  endtask

  function automatic logic [81:0] main_out();
    return {x1, x2, x3, x4, y1, y2, y3, y4, step, frz};
  endfunction

  function automatic logic [81:0] wrap_out();
    return {wx1, wx2, wx3, wx4, wy1, wy2, wy3, wy4, w_step, w_frz};
  endfunction

  initial begin
    //            rst  run  tick coll lvl    x1     x2      x3      x4    step frz
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,2'd0, 10'd0, 10'd160,10'd320,10'd480,1'b0,1'b0}; // reset
    vecs[1]  = '{1'b1,1'b0,1'b1,1'b1,2'd0, 10'd0, 10'd160,10'd320,10'd480,1'b0,1'b0}; // reset wins
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,2'd0, 10'd0, 10'd160,10'd320,10'd480,1'b0,1'b0}; // idle tick
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,2'd0, 10'd0, 10'd160,10'd320,10'd480,1'b0,1'b0}; // -> RUN
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 10'd0, 10'd160,10'd320,10'd479,1'b1,1'b0}; // tick 1
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,2'd0, 10'd0, 10'd160,10'd320,10'd479,1'b0,1'b0}; // step 1 cycle
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 10'd0, 10'd160,10'd321,10'd478,1'b1,1'b0}; // tick 2
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 10'd0, 10'd159,10'd321,10'd477,1'b1,1'b0}; // tick 3
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b1,1'b0}; // tick 4
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b0,1'b0}; // pause
    vecs[10] = '{1'b0,1'b0,1'b1,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,2'd0, 10'd1, 10'd159,10'd322,10'd476,1'b0,1'b0}; // resume
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0,2'd1, 10'd1, 10'd159,10'd322,10'd474,1'b1,1'b0}; // s=2
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0,2'd1, 10'd1, 10'd157,10'd324,10'd472,1'b1,1'b0}; // phase kept
    vecs[16] = '{1'b0,1'b1,1'b1,1'b0,2'd2, 10'd1, 10'd157,10'd324,10'd469,1'b1,1'b0}; // s=3
    vecs[17] = '{1'b0,1'b1,1'b1,1'b1,2'd0, 10'd1, 10'd157,10'd324,10'd469,1'b0,1'b1}; // coll > tick

    w_rst = 1'b1; w_run = 1'b0; w_tick = 1'b0; w_coll = 1'b0; w_lvl = 2'd0;
    rst = 1'b1; run = 1'b0; tick = 1'b0; coll = 1'b0; lvl = 2'd0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].rst, vecs[i].run, vecs[i].tick, vecs[i].coll, vecs[i].lvl);
      check($sformatf("vec%0d", i), main_out(), vecs[i].x1, vecs[i].x2, vecs[i].x3,
            vecs[i].x4, vecs[i].step, vecs[i].frz);
    end

    // Frozen: 59 ticks hold, inputs other than tick ignored, gaps between ticks.
    for (int t = 1; t <= 59; t++) begin
      cyc(1'b0, t[0], 1'b1, t[1], 2'd3);
      if (t % 10 == 0 || t == 59)
        check($sformatf("freeze_hold%0d", t), main_out(), 10'd1, 10'd157, 10'd324, 10'd469, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    check("freeze_release", main_out(), 10'd0, 10'd160, 10'd320, 10'd480, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("post_freeze_idle", main_out(), 10'd0, 10'd160, 10'd320, 10'd480, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    check("post_freeze_move", main_out(), 10'd0, 10'd160, 10'd320, 10'd479, 1'b1, 1'b0);

    // Reset in the middle of a freeze.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check("freeze_again", main_out(), 10'd0, 10'd160, 10'd321, 10'd478, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    check("reset_in_freeze", main_out(), 10'd0, 10'd160, 10'd320, 10'd480, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("idle_after_reset", main_out(), 10'd0, 10'd160, 10'd320, 10'd480, 1'b0, 1'b0);

    // Wrap-around at both screen edges with the largest step.
    wcyc(1'b1, 1'b0, 1'b0, 2'd3);
    wcyc(1'b1, 1'b0, 1'b0, 2'd3);
    check("wrap_reset", wrap_out(), 10'd638, 10'd160, 10'd320, 10'd0, 1'b0, 1'b0);
    wcyc(1'b0, 1'b1, 1'b0, 2'd3);
    wcyc(1'b0, 1'b1, 1'b1, 2'd3);
    check("wrap_tick1", wrap_out(), 10'd2, 10'd160, 10'd320, 10'd636, 1'b1, 1'b0);
    wcyc(1'b0, 1'b1, 1'b1, 2'd3);
    check("wrap_tick2", wrap_out(), 10'd6, 10'd160, 10'd324, 10'd632, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
